// File: rtl/i2s_rx_dsp_channel.sv
// DSP-mode (frame-sync) I2S receive channel: deserialises ch0/ch1 after a programmable
// frame-sync offset and pushes 32-bit words to the uDMA RX FIFO. Optional `I2S_RX_SIGN_EXT_EN.
module i2s_rx_dsp_channel (
  input  logic        sck_i,
  input  logic        rstn_i,
  input  logic        i2s_ch0_i,
  input  logic        i2s_ch1_i,
  input  logic        i2s_ws_i,
  output logic [31:0] fifo_data_o,
  output logic        fifo_data_valid_o,
  input  logic        fifo_data_ready_i,
  output logic        fifo_err_o,
  input  logic        cfg_en_i,
  input  logic        cfg_2ch_i,
  input  logic [4:0]  cfg_num_bits_i,
  input  logic        cfg_lsb_first_i,
  input  logic [8:0]  cfg_slave_dsp_offset_i
`ifdef I2S_RX_SIGN_EXT_EN
  ,
  input  logic        cfg_sign_ext_i
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_FS, OFFSET, RUN} state_e;

  state_e      state_q, state_d;
  logic [8:0]  off_cnt_q, off_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] sr0_q, sr0_d, sr1_q, sr1_d;
  logic [31:0] pend0_q, pend0_d, pend1_q, pend1_d;
  logic        pend0_vld_q, pend0_vld_d, pend1_vld_q, pend1_vld_d;
  logic [31:0] dat_q, dat_d;
  logic        vld_q, vld_d;
  logic        sel_q, sel_d;
  logic        err_q, err_d;
  logic        cfg_2ch_q, cfg_2ch_d;
  logic [4:0]  cfg_nb_q, cfg_nb_d;
  logic        cfg_lsb_q, cfg_lsb_d;
  logic [8:0]  cfg_off_q, cfg_off_d;
  logic        sext_en;

`ifdef I2S_RX_SIGN_EXT_EN
  logic cfg_sext_q, cfg_sext_d;
  assign sext_en = cfg_sext_q;
`else
  assign sext_en = 1'b0;
`endif

  logic [31:0] sr0_n, sr1_n;
  logic        acc, pend0_keep, pend1_keep, word_done, fs;

  // Bits above the word length are forced to 0, or to the sign bit when extending.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [4:0] nb, input logic s);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF >> (5'd31 - nb);
    if (s && w[nb]) return w | ~mask;
    return w & mask;
  endfunction

  always_comb begin
    state_d     = state_q;
    off_cnt_d   = off_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sr0_d       = sr0_q;
    sr1_d       = sr1_q;
    pend0_d     = pend0_q;
    pend1_d     = pend1_q;
    dat_d       = dat_q;
    vld_d       = vld_q;
    sel_d       = sel_q;
    err_d       = 1'b0;
    cfg_2ch_d   = cfg_2ch_q;
    cfg_nb_d    = cfg_nb_q;
    cfg_lsb_d   = cfg_lsb_q;
    cfg_off_d   = cfg_off_q;
`ifdef I2S_RX_SIGN_EXT_EN
    cfg_sext_d  = cfg_sext_q;
`endif
    word_done   = 1'b0;
    fs          = 1'b0;

    sr0_n = cfg_lsb_q ? sr0_q : {sr0_q[30:0], i2s_ch0_i};
    sr1_n = cfg_lsb_q ? sr1_q : {sr1_q[30:0], i2s_ch1_i};
    if (cfg_lsb_q) begin
      sr0_n[bit_cnt_q] = i2s_ch0_i;
      sr1_n[bit_cnt_q] = i2s_ch1_i;
    end

    acc         = vld_q & fifo_data_ready_i;
    pend0_keep  = pend0_vld_q & ~(acc & ~sel_q);
    pend1_keep  = pend1_vld_q & ~(acc & sel_q);
    pend0_vld_d = pend0_keep;
    pend1_vld_d = pend1_keep;

    // Output register is refilled from the slots as they stood before this edge,
    // which gives the one-cycle delay from word done to valid.
    if (!vld_q || acc) begin
      if (pend0_keep) begin
        dat_d = pend0_q;
        vld_d = 1'b1;
        sel_d = 1'b0;
      end else if (pend1_keep) begin
        dat_d = pend1_q;
        vld_d = 1'b1;
        sel_d = 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (cfg_en_i) state_d = WAIT_FS;
      end
      WAIT_FS: begin
        if (i2s_ws_i) fs = 1'b1;
      end
      OFFSET: begin
        off_cnt_d = off_cnt_q + 9'd1;
        if (({1'b0, off_cnt_q} + 10'd1) == {1'b0, cfg_off_q}) begin
          state_d   = RUN;
          bit_cnt_d = '0;
          sr0_d     = '0;
          sr1_d     = '0;
        end
      end
      RUN: begin
        sr0_d     = sr0_n;
        sr1_d     = cfg_2ch_q ? sr1_n : 32'd0;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == cfg_nb_q) begin
          word_done = 1'b1;
          state_d   = WAIT_FS;
          if (i2s_ws_i) fs = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (pend0_keep || pend1_keep) begin
        err_d = 1'b1;
      end else begin
        pend0_d     = extend(sr0_n, cfg_nb_q, sext_en);
        pend0_vld_d = 1'b1;
        if (cfg_2ch_q) begin
          pend1_d     = extend(sr1_n, cfg_nb_q, sext_en);
          pend1_vld_d = 1'b1;
        end
      end
    end

    if (fs) begin
      cfg_2ch_d  = cfg_2ch_i;
      cfg_nb_d   = cfg_num_bits_i;
      cfg_lsb_d  = cfg_lsb_first_i;
      cfg_off_d  = cfg_slave_dsp_offset_i;
`ifdef I2S_RX_SIGN_EXT_EN
      cfg_sext_d = cfg_sign_ext_i;
`endif
      off_cnt_d  = '0;
      bit_cnt_d  = '0;
      sr0_d      = '0;
      sr1_d      = '0;
      state_d    = (cfg_slave_dsp_offset_i == 9'd0) ? RUN : OFFSET;
    end

    if (!cfg_en_i) begin
      state_d     = IDLE;
      off_cnt_d   = '0;
      bit_cnt_d   = '0;
      sr0_d       = '0;
      sr1_d       = '0;
      pend0_d     = '0;
      pend1_d     = '0;
      pend0_vld_d = 1'b0;
      pend1_vld_d = 1'b0;
      dat_d       = '0;
      vld_d       = 1'b0;
      sel_d       = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      off_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sr0_q       <= '0;
      sr1_q       <= '0;
      pend0_q     <= '0;
      pend1_q     <= '0;
      pend0_vld_q <= 1'b0;
      pend1_vld_q <= 1'b0;
      dat_q       <= '0;
      vld_q       <= 1'b0;
      sel_q       <= 1'b0;
      err_q       <= 1'b0;
      cfg_2ch_q   <= 1'b0;
      cfg_nb_q    <= '0;
      cfg_lsb_q   <= 1'b0;
      cfg_off_q   <= '0;
`ifdef I2S_RX_SIGN_EXT_EN
      cfg_sext_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      off_cnt_q   <= off_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr0_q       <= sr0_d;
      sr1_q       <= sr1_d;
      pend0_q     <= pend0_d;
      pend1_q     <= pend1_d;
      pend0_vld_q <= pend0_vld_d;
      pend1_vld_q <= pend1_vld_d;
      dat_q       <= dat_d;
      vld_q       <= vld_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      cfg_2ch_q   <= cfg_2ch_d;
      cfg_nb_q    <= cfg_nb_d;
      cfg_lsb_q   <= cfg_lsb_d;
      cfg_off_q   <= cfg_off_d;
`ifdef I2S_RX_SIGN_EXT_EN
      cfg_sext_q  <= cfg_sext_d;
`endif
    end
  end

  assign fifo_data_o       = dat_q;
  assign fifo_data_valid_o = vld_q;
  assign fifo_err_o        = err_q;

endmodule

// File: tb/tb_i2s_rx_dsp_channel.sv
// Directed bench for i2s_rx_dsp_channel; inputs change 1ns after posedge, outputs are checked there.
module tb_i2s_rx_dsp_channel;

  logic        sck = 1'b0;
  logic        rstn;
  logic        ch0, ch1, ws;
  logic [31:0] fifo_data;
  logic        fifo_valid, fifo_ready, fifo_err;
  logic        en, two_ch, lsb;
  logic [4:0]  nb;
  logic [8:0]  off;
`ifdef I2S_RX_SIGN_EXT_EN
  logic        sext;
`endif

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  logic [31:0] rx_q[$];

  always #5 sck = ~sck;

  i2s_rx_dsp_channel dut (
    .sck_i                  (sck),
    .rstn_i                 (rstn),
    .i2s_ch0_i              (ch0),
    .i2s_ch1_i              (ch1),
    .i2s_ws_i               (ws),
    .fifo_data_o            (fifo_data),
    .fifo_data_valid_o      (fifo_valid),
    .fifo_data_ready_i      (fifo_ready),
    .fifo_err_o             (fifo_err),
    .cfg_en_i               (en),
    .cfg_2ch_i              (two_ch),
    .cfg_num_bits_i         (nb),
    .cfg_lsb_first_i        (lsb),
    .cfg_slave_dsp_offset_i (off)
`ifdef I2S_RX_SIGN_EXT_EN
    ,
    .cfg_sign_ext_i         (sext)
`endif
  );

  // Handshakes complete on the following posedge; record them mid-cycle.
  always @(negedge sck) begin
    if (rstn && fifo_valid && fifo_ready) rx_q.push_back(fifo_data);
    if (rstn && fifo_err) err_pulses++;
  end

  task automatic step();
    @(posedge sck);
    #1;
  endtask

  task automatic pulse_ws();
    ws = 1'b1;
    step();
    ws = 1'b0;
  endtask

  task automatic shift_word(input logic [31:0] w0, input logic [31:0] w1, input bit ws_last);
    logic [31:0] a, b;
    int idx;
    a = w0;
    b = w1;
    for (int i = 0; i <= int'(nb); i++) begin
      idx = lsb ? i : int'(nb) - i;
      ch0 = a[idx];
      ch1 = b[idx];
      ws  = ws_last && (i == int'(nb));
      step();
    end
    ws  = 1'b0;
    ch0 = 1'b0;
    ch1 = 1'b0;
  endtask

  task automatic check_rx(input string name, input int n, input logic [31:0] e0, input logic [31:0] e1);
    checks++;
    if (rx_q.size() != n) begin
      errors++;
      $display("FAIL %s count: got %0d words, expected %0d", name, rx_q.size(), n);
    end else begin
      checks++;
      if (rx_q[0] !== e0) begin
        errors++;
        $display("FAIL %s word0: got %h expected %h", name, rx_q[0], e0);
      end
      if (n > 1) begin
        checks++;
        if (rx_q[1] !== e1) begin
          errors++;
          $display("FAIL %s word1: got %h expected %h", name, rx_q[1], e1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; two_ch = 1'b1; nb = 5'd7; lsb = 1'b0; off = '0;
    ch0 = 1'b1; ch1 = 1'b1; ws = 1'b1; fifo_ready = 1'b1;
`ifdef I2S_RX_SIGN_EXT_EN
    sext = 1'b0;
`endif
    step(); step();
    checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", fifo_valid); end
    checks++; if (fifo_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", fifo_data); end
    checks++; if (fifo_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", fifo_err); end
    en = 1'b0; ws = 1'b0; ch0 = 1'b0; ch1 = 1'b0;
    rstn = 1'b1;
    step();
  endtask

  task automatic test_msb_16();
    rx_q.delete(); err_pulses = 0;
    en = 1'b1; two_ch = 1'b0; nb = 5'd15; lsb = 1'b0; off = 9'd0; fifo_ready = 1'b1;
    step();
    pulse_ws();
    shift_word(32'hA5C3, 32'h0, 1'b0);
    checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL msb16_early_valid: got %b expected 0", fifo_valid); end
    step();
    checks++; if (fifo_valid !== 1'b1) begin errors++; $display("FAIL msb16_valid: got %b expected 1", fifo_valid); end
    checks++; if (fifo_data !== 32'h0000A5C3) begin errors++; $display("FAIL msb16_data: got %h expected 0000a5c3", fifo_data); end
    step();
    checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL msb16_valid_drop: got %b expected 0", fifo_valid); end
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL msb16_err: got %0d pulses expected 0", err_pulses); end
  endtask

  task automatic test_2ch_lsb_offset();
    rx_q.delete();
    two_ch = 1'b1; nb = 5'd7; lsb = 1'b1; off = 9'd3;
    pulse_ws();
    // Offset-window values differ from the first data bits, so misalignment corrupts the word.
    for (int i = 0; i < 3; i++) begin
      ch0 = 1'b0; ch1 = 1'b1;
      step();
    end
    shift_word(32'h81, 32'h7E, 1'b0);
    repeat (6) step();
    check_rx("2ch_lsb_off3", 2, 32'h00000081, 32'h0000007E);
  endtask

  task automatic test_back_to_back();
    rx_q.delete(); err_pulses = 0;
    two_ch = 1'b0; nb = 5'd31; lsb = 1'b0; off = 9'd0;
    pulse_ws();
    shift_word(32'hDEADBEEF, 32'h0, 1'b1);
    shift_word(32'h12345678, 32'h0, 1'b0);
    repeat (6) step();
    check_rx("back_to_back", 2, 32'hDEADBEEF, 32'h12345678);
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL b2b_err: got %0d pulses expected 0", err_pulses); end
  endtask

  task automatic test_overflow();
    rx_q.delete(); err_pulses = 0;
    fifo_ready = 1'b0; two_ch = 1'b1; nb = 5'd7; lsb = 1'b0; off = 9'd0;
    pulse_ws();
    shift_word(32'h11, 32'h22, 1'b0);
    step(); step();
    checks++; if (fifo_valid !== 1'b1 || fifo_data !== 32'h11) begin errors++; $display("FAIL ovf_hold1: got valid=%b data=%h expected 1/00000011", fifo_valid, fifo_data); end
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL ovf_early_err: got %0d pulses expected 0", err_pulses); end
    pulse_ws();
    shift_word(32'h33, 32'h44, 1'b0);
    repeat (3) step();
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL ovf_err_pulses: got %0d expected 1", err_pulses); end
    checks++; if (fifo_valid !== 1'b1 || fifo_data !== 32'h11) begin errors++; $display("FAIL ovf_hold2: got valid=%b data=%h expected 1/00000011", fifo_valid, fifo_data); end
    fifo_ready = 1'b1;
    repeat (6) step();
    check_rx("overflow_drain", 2, 32'h11, 32'h22);
  endtask

  task automatic test_en_drop();
    rx_q.delete();
    fifo_ready = 1'b0; two_ch = 1'b0; nb = 5'd15; lsb = 1'b0; off = 9'd0;
    pulse_ws();
    shift_word(32'hFFFF, 32'h0, 1'b0);
    step(); step();
    checks++; if (fifo_valid !== 1'b1) begin errors++; $display("FAIL endrop_pre_valid: got %b expected 1", fifo_valid); end
    pulse_ws();
    for (int i = 0; i < 5; i++) begin
      ch0 = 1'b1;
      step();
    end
    en = 1'b0;
    step();
    checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL endrop_valid: got %b expected 0", fifo_valid); end
    checks++; if (fifo_data !== 32'd0) begin errors++; $display("FAIL endrop_data: got %h expected 0", fifo_data); end
    ch0 = 1'b0;
    fifo_ready = 1'b1;
    en = 1'b1;
    step();
    pulse_ws();
    shift_word(32'h1234, 32'h0, 1'b0);
    repeat (6) step();
    check_rx("endrop_reenable", 1, 32'h00001234, 32'h0);
  endtask

  task automatic test_sign_ext();
    two_ch = 1'b0; nb = 5'd11; lsb = 1'b0; off = 9'd0; fifo_ready = 1'b1;
`ifdef I2S_RX_SIGN_EXT_EN
    rx_q.delete();
    sext = 1'b1;
    pulse_ws();
    shift_word(32'h800, 32'h0, 1'b0);
    repeat (6) step();
    check_rx("sext_on", 1, 32'hFFFFF800, 32'h0);
    rx_q.delete();
    sext = 1'b0;
    pulse_ws();
    shift_word(32'h800, 32'h0, 1'b0);
    repeat (6) step();
    check_rx("sext_off", 1, 32'h00000800, 32'h0);
`else
    rx_q.delete();
    pulse_ws();
    shift_word(32'h800, 32'h0, 1'b0);
    repeat (6) step();
    check_rx("zext_800", 1, 32'h00000800, 32'h0);
    rx_q.delete();
    pulse_ws();
    shift_word(32'hFFF, 32'h0, 1'b0);
    repeat (6) step();
    check_rx("zext_fff", 1, 32'h00000FFF, 32'h0);
`endif
  endtask

  initial begin
    test_reset();
    test_msb_16();
    test_2ch_lsb_offset();
    test_back_to_back();
    test_overflow();
    test_en_drop();
    test_sign_ext();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
